// File: rtl/reset_seq.sv
// reset_seq -- staged reset release sequencer.
//
// Releases NUM_STAGES downstream reset domains one at a time, in index order.
// Before each release the sequencer waits DLY_CYCLES clocks. After each release
// it waits for that stage's acknowledge before moving on to the next stage.
// The fabric reset is resynchronised first. Whenever it is low, every stage
// is forced back into reset and the sequence starts again from stage 0.
//
// Optional feature macro: RESET_SEQ_TIMEOUT_EN
//   defined   : a stage that fails to acknowledge within ACK_TIMEOUT cycles
//               sends the sequencer to ERROR. In ERROR all stages are held in
//               reset and seq_err is set. ERROR is left only through reset or
//               a low fabric reset.
//   undefined : the sequencer waits for the acknowledge indefinitely and
//               seq_err is tied to 0.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   fabric_reset_n  in   active-low fabric reset, may be asynchronous to clk
//   stage_ack       in   [NUM_STAGES] per-stage ready acknowledge (level)
//   stage_reset_n   out  [NUM_STAGES] per-stage active-low reset, registered
//   seq_done        out  all stages released and acknowledged, registered
//   seq_err         out  sticky acknowledge-timeout flag, registered
//   cur_stage       out  index of the stage currently being released
module reset_seq #(
    parameter int NUM_STAGES  = 4,
    parameter int DLY_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1024,
    localparam int CUR_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fabric_reset_n,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [CUR_W-1:0]      cur_stage
);

    if (DLY_CYCLES < 1 || DLY_CYCLES > 65535 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_param
        $error("reset_seq: DLY_CYCLES and ACK_TIMEOUT must be in 1..65535");
    end

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        DELAY    = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam logic [15:0]      DLY_TERM = 16'(DLY_CYCLES - 1);
    localparam logic [CUR_W-1:0] LAST     = CUR_W'(NUM_STAGES - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic                  fr_meta_p0;
    logic                  fr_s_p1;
    state_t                state_q, state_d;
    logic [15:0]           dly_q, dly_d;
    logic [CUR_W-1:0]      cur_q, cur_d;
    logic [NUM_STAGES-1:0] rstn_q, rstn_d;
    logic                  done_q, done_d;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_TERM = 16'(ACK_TIMEOUT - 1);
    logic [15:0]           to_q, to_d;
    logic                  err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rstn_d  = rstn_q;
        done_d  = 1'b0;
        // Counters clear on every state change; only their own state advances them.
        dly_d   = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
        to_d    = '0;
        err_d   = 1'b0;
`endif
        case (state_q)
            HOLD: begin
                rstn_d = '0;
                cur_d  = '0;
                if (fr_s_p1) state_d = DELAY;
            end
            DELAY: begin
                if (dly_q >= DLY_TERM) begin
                    rstn_d[cur_q] = 1'b1;
                    state_d       = WAIT_ACK;
                end else begin
                    dly_d = sat_inc(dly_q);
                end
            end
            WAIT_ACK: begin
                // Only the current stage's acknowledge is looked at.
                if (stage_ack[cur_q]) begin
                    if (cur_q == LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = DELAY;
                    end
                end
`ifdef RESET_SEQ_TIMEOUT_EN
                else if (to_q >= TO_TERM) begin
                    state_d = ERROR;
                    rstn_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    to_d = sat_inc(to_q);
                end
`endif
            end
            DONE: begin
                done_d = 1'b1;
            end
            ERROR: begin
                rstn_d = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
                err_d  = 1'b1;
`endif
            end
            default: begin
                state_d = HOLD;
                rstn_d  = '0;
                cur_d   = '0;
            end
        endcase

        // A low synchronised fabric reset wins over everything above.
        if (!fr_s_p1) begin
            state_d = HOLD;
            rstn_d  = '0;
            cur_d   = '0;
            done_d  = 1'b0;
            dly_d   = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
            to_d    = '0;
            err_d   = 1'b0;
`endif
        end
    end

    // Stage p0/p1: two-flop resynchroniser, then FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fr_meta_p0 <= 1'b0;
            fr_s_p1    <= 1'b0;
            state_q    <= HOLD;
            dly_q      <= '0;
            cur_q      <= '0;
            rstn_q     <= '0;
            done_q     <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            to_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            fr_meta_p0 <= fabric_reset_n;
            fr_s_p1    <= fr_meta_p0;
            state_q    <= state_d;
            dly_q      <= dly_d;
            cur_q      <= cur_d;
            rstn_q     <= rstn_d;
            done_q     <= done_d;
`ifdef RESET_SEQ_TIMEOUT_EN
            to_q       <= to_d;
            err_q      <= err_d;
`endif
        end
    end

    assign stage_reset_n = rstn_q;
    assign seq_done      = done_q;
    assign cur_stage     = cur_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    assign seq_err       = err_q;
`else
    assign seq_err       = 1'b0;
`endif

endmodule
